ex_muldiv_unit: RTL and testbench

- Execute-stage iterative multiply/divide unit with architectural HI/LO registers.
- Consumes the operand and control outputs of the ID/EX pipeline register.
- Runs MULT/MULTU/DIV/DIVU in the background while independent instructions continue.
- Raises a stall request to the ID/EX register and hazard logic when a later instruction needs HI/LO, or needs the unit, before it finishes.

---
 rtl/ex_muldiv_unit_pkg.sv | 30 +++
 rtl/ex_muldiv_unit_if.sv | 27 ++
 rtl/ex_muldiv_unit_core.sv | 57 +++++
 rtl/ex_muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared CPU definitions used by the execute-stage multiply/divide unit:
// mul/div op encodings and the iteration FSM states.
package cpu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-facing bundle of the multiply/divide unit: operands and control in,
// HI/LO, status and stall request out.
interface ex_muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            md_start;
    logic [2:0]      md_op;
    logic            ex_flush;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            mf_req;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;
    logic            busy;
    logic            done;
    logic            stall_o;

    modport slave (
        input  md_start, md_op, ex_flush, src_a, src_b, mf_req,
        output hi_o, lo_o, busy, done, stall_o
    );

    modport master (
        output md_start, md_op, ex_flush, src_a, src_b, mf_req,
        input  hi_o, lo_o, busy, done, stall_o
    );
endinterface

// File: rtl/ex_muldiv_unit_core.sv
// Iterative shift datapath: shift-add multiply or restoring divide on unsigned
// magnitudes, one bit per step, with the iteration counter.
module muldiv_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       step,
    input  logic                       is_div,
    input  logic [XLEN-1:0]            op_a,
    input  logic [XLEN-1:0]            op_b,
    output logic [2*XLEN-1:0]          acc,
    output logic [$clog2(XLEN):0]      cnt
);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]   opnd_b;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN:0]   div_shift;
    logic [XLEN:0]     div_rem;
    logic [XLEN:0]     div_sub;
    logic [2*XLEN-1:0] acc_next;

    // acc = {HI-half, LO-half}: multiply adds into the top and shifts right,
    // divide shifts left and builds the quotient in the low half.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_b} : '0);
        div_shift = {acc, 1'b0};
        div_rem   = div_shift[2*XLEN:XLEN];
        div_sub   = div_rem - {1'b0, opnd_b};
        acc_next  = {mul_sum, acc[XLEN-1:1]};
        if (is_div) begin
            if (div_rem >= {1'b0, opnd_b}) begin
                acc_next = {div_sub[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
            end else begin
                acc_next = {div_rem[XLEN-1:0], div_shift[XLEN-1:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            opnd_b <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= {{XLEN{1'b0}}, op_a};
            opnd_b <= op_b;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide unit: FSM, operand sign handling, result
// fix-up, architectural HI/LO and the pipeline stall request.
module ex_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    ex_muldiv_unit_if.slave  md
);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    md_state_e         state_q, state_d;
    md_op_e            op;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic              done_q;
    logic              neg_res_q, neg_rem_q, div_zero_q, is_div_q;
    logic [XLEN-1:0]   dividend_q;

    logic              accept, a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              load, step, fix, mt_hi, mt_lo;
    logic [2*XLEN-1:0] acc, prod;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   res_hi, res_lo;

    assign op = md_op_e'(md.md_op);

    always_comb begin
        accept = (state_q == IDLE) && md.md_start && !md.ex_flush && (op != MD_NONE);
        a_neg  = md_is_signed(op) && md.src_a[XLEN-1];
        b_neg  = md_is_signed(op) && md.src_b[XLEN-1];
        abs_a  = a_neg ? -md.src_a : md.src_a;
        abs_b  = b_neg ? -md.src_b : md.src_b;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            state_d = MUL;
                            load    = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d = DIV;
                            load    = 1'b1;
                        end
                        MD_MTHI: mt_hi = 1'b1;
                        MD_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                step = 1'b1;
                if (cnt == CNT_W'(XLEN - 1)) state_d = FIX;
            end
            FIX: begin
                fix     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .is_div (state_q == DIV),
        .op_a   (abs_a),
        .op_b   (abs_b),
        .acc    (acc),
        .cnt    (cnt)
    );

    // Divide-by-zero bypasses sign correction: HI returns the raw dividend.
    always_comb begin
        prod   = neg_res_q ? -acc : acc;
        res_hi = prod[2*XLEN-1:XLEN];
        res_lo = prod[XLEN-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                res_hi = dividend_q;
                res_lo = '1;
            end else begin
                res_hi = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
                res_lo = neg_res_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            is_div_q   <= 1'b0;
            dividend_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= fix;
            if (load) begin
                neg_res_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                div_zero_q <= (md.src_b == '0);
                is_div_q   <= md_is_div(op);
                dividend_q <= md.src_a;
            end
            if (fix) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else begin
                if (mt_hi) hi_q <= md.src_a;
                if (mt_lo) lo_q <= md.src_a;
            end
        end
    end

    assign md.hi_o    = hi_q;
    assign md.lo_o    = lo_q;
    assign md.busy    = (state_q != IDLE);
    assign md.done    = done_q;
    assign md.stall_o = (state_q != IDLE) && ((md.md_start && !md.ex_flush) || md.mf_req);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed ops push expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_ex_muldiv_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.XLEN(32)) bus ();

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.md_start = 1'b1;
        bus.md_op    = op;
        bus.src_a    = a;
        bus.src_b    = b;
    endtask

    task automatic release_inputs();
        bus.md_start = 1'b0;
        bus.md_op    = MD_NONE;
        bus.ex_flush = 1'b0;
        bus.mf_req   = 1'b0;
    endtask

    // Issue a mul/div, check busy spans 33 cycles and done follows, then done drops.
    task automatic run_op(input string name, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        int n;
        tick();
        issue(op, a, b);
        exp_q.push_back({hi, lo});
        tick();
        release_inputs();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            tick();
        end
        check({name, "_busy_cycles"}, 32'(n), 32'd33);
        check({name, "_done_pulse"}, 32'(bus.done), 32'd1);
        tick();
        @(negedge clk);
        check({name, "_done_drop"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected no pending result");
                end else begin
                    e = exp_q.pop_front();
                    check("hi_result", bus.hi_o, e[63:32]);
                    check("lo_result", bus.lo_o, e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion before 100000ns");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int dones;
        rst = 1'b1;
        bus.src_a = '0;
        bus.src_b = '0;
        release_inputs();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_hi", bus.hi_o, 32'h0);
        check("reset_lo", bus.lo_o, 32'h0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_stall", 32'(bus.stall_o), 32'd0);

        run_op("mult_neg",   MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_max",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("div_neg",    MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",       MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        run_op("divu_zero",  MD_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
        run_op("div_ovf",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
        run_op("div_zero_s", MD_DIV,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF);

        // MULT 5x6, then MFLO and a second MULT held behind it
        tick();
        issue(MD_MULT, 32'd5, 32'd6);
        exp_q.push_back({32'd0, 32'd30});
        tick();
        release_inputs();
        @(negedge clk);
        check("stall_cycle_k", 32'(bus.stall_o), 32'd0);
        tick();
        bus.mf_req = 1'b1;
        issue(MD_MULT, 32'd3, 32'd4);
        exp_q.push_back({32'd0, 32'd12});
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.stall_o) break;
            n++;
            tick();
        end
        check("stall_cycles", 32'(n), 32'd32);
        check("mflo_read", bus.lo_o, 32'd30);
        check("mfhi_read", bus.hi_o, 32'd0);
        check("idle_at_release", 32'(bus.busy), 32'd0);
        tick();
        release_inputs();
        @(negedge clk);
        check("second_accepted", 32'(bus.busy), 32'd1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        check("second_busy_tail", 32'(n), 32'd32);

        // flushed start is ignored; MTHI/MTLO write in one edge
        tick();
        issue(MD_MULT, 32'd9, 32'd9);
        bus.ex_flush = 1'b1;
        tick();
        release_inputs();
        @(negedge clk);
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_hi", bus.hi_o, 32'd0);
        check("flush_lo", bus.lo_o, 32'd12);
        tick();
        issue(MD_MTHI, 32'h00001234, 32'h0);
        tick();
        release_inputs();
        @(negedge clk);
        check("mthi_hi", bus.hi_o, 32'h00001234);
        check("mthi_lo", bus.lo_o, 32'd12);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        check("mthi_done", 32'(bus.done), 32'd0);
        tick();
        issue(MD_MTLO, 32'h0000ABCD, 32'h0);
        tick();
        release_inputs();
        @(negedge clk);
        check("mtlo_lo", bus.lo_o, 32'h0000ABCD);
        check("mtlo_hi", bus.hi_o, 32'h00001234);

        // reset in cycle k+10 of a DIV aborts it
        tick();
        issue(MD_DIV, 32'd100, 32'd7);
        tick();
        release_inputs();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.hi_o, 32'd0);
        check("abort_lo", bus.lo_o, 32'd0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op("mult_after_rst", MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12);

        tick();
        tick();
        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
